// File: rtl/double_multiplier_core.sv
// Fully pipelined IEEE-754 single-precision multiplier.
// Operands are registered on every edge where ready=1. A result appears on
// res with a one-cycle done pulse four edges after the operands were captured.
// Denormal inputs are flushed to zero, rounding is round-to-nearest-even, and
// NaN outputs always carry an all-ones mantissa.
module double_multiplier_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] res,
    output logic        done
);
    localparam int STAGES = 4;

    // Unpacked operands plus classification flags (S1 -> S2)
    typedef struct packed {
        logic        s;
        logic [9:0]  e;
        logic [23:0] ma;
        logic [23:0] mb;
        logic        nan;
        logic        inf;
        logic        zero;
    } s1_t;

    // Raw significand product (S2 -> S3)
    typedef struct packed {
        logic        s;
        logic [9:0]  e;
        logic [47:0] prod;
        logic        nan;
        logic        inf;
        logic        zero;
    } s2_t;

    // vld_pipe[0] = capture register, [1..3] = S1..S3, [4] = output register
    logic [STAGES:0] vld_pipe;
    logic [31:0]     a_q, b_q;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    logic [31:0]     s3_d, s3_q;

    // Valid shift register; reset drops every in-flight result
    always_ff @(posedge clk) begin
        if (!rst) vld_pipe <= '0;
        else      vld_pipe <= {vld_pipe[STAGES-1:0], ready};
    end

    assign done = vld_pipe[STAGES];

    // Operand capture
    always_ff @(posedge clk) begin
        if (rst && ready) begin
            a_q <= op1;
            b_q <= op2;
        end
    end

    // S1: unpack and classify; exponent zero means zero or denormal, both flushed
    always_comb begin
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        s1_d   = '0;
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        fa     = a_q[22:0];
        fb     = b_q[22:0];
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (fa == 23'h0);
        b_inf  = (eb == 8'hFF) && (fb == 23'h0);
        a_nan  = (ea == 8'hFF) && (fa != 23'h0);
        b_nan  = (eb == 8'hFF) && (fb != 23'h0);
        s1_d.s    = a_q[31] ^ b_q[31];
        s1_d.e    = {2'b00, ea} + {2'b00, eb} - 10'd127;
        s1_d.ma   = {1'b1, fa};
        s1_d.mb   = {1'b1, fb};
        s1_d.nan  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
        s1_d.inf  = a_inf | b_inf;
        s1_d.zero = a_zero | b_zero;
    end

    // S1 register
    always_ff @(posedge clk) begin
        if (rst && vld_pipe[0]) s1_q <= s1_d;
    end

    // S2: 24x24 significand multiply, hidden bits included
    always_comb begin
        s2_d      = '0;
        s2_d.s    = s1_q.s;
        s2_d.e    = s1_q.e;
        s2_d.prod = {24'h0, s1_q.ma} * {24'h0, s1_q.mb};
        s2_d.nan  = s1_q.nan;
        s2_d.inf  = s1_q.inf;
        s2_d.zero = s1_q.zero;
    end

    // S2 register
    always_ff @(posedge clk) begin
        if (rst && vld_pipe[1]) s2_q <= s2_d;
    end

    // S3: normalize, round to nearest even, range-check, resolve special cases
    always_comb begin
        logic [22:0] mant;
        logic        guard, sticky, rnd;
        logic [24:0] mr;
        logic [9:0]  e_n, e_f;
        logic [22:0] frac;
        logic        ovf, udf;
        // product of two [1,2) significands is in [1,4); bit 47 flags the [2,4) case
        if (s2_q.prod[47]) begin
            mant   = s2_q.prod[46:24];
            guard  = s2_q.prod[23];
            sticky = |s2_q.prod[22:0];
            e_n    = s2_q.e + 10'd1;
        end else begin
            mant   = s2_q.prod[45:23];
            guard  = s2_q.prod[22];
            sticky = |s2_q.prod[21:0];
            e_n    = s2_q.e;
        end
        rnd = guard & (sticky | mant[0]);
        mr  = {2'b01, mant} + {24'h0, rnd};
        // all-ones mantissa rounding up carries into bit 24: renormalize
        if (mr[24]) begin
            frac = mr[23:1];
            e_f  = e_n + 10'd1;
        end else begin
            frac = mr[22:0];
            e_f  = e_n;
        end
        ovf = ($signed(e_f) >= 10'sd255);
        udf = ($signed(e_f) <= 10'sd0);
        if (s2_q.nan)       s3_d = {s2_q.s, 8'hFF, 23'h7FFFFF};
        else if (s2_q.inf)  s3_d = {s2_q.s, 8'hFF, 23'h0};
        else if (s2_q.zero) s3_d = {s2_q.s, 31'h0};
        else if (ovf)       s3_d = {s2_q.s, 8'hFF, 23'h0};
        else if (udf)       s3_d = {s2_q.s, 31'h0};
        else                s3_d = {s2_q.s, e_f[7:0], frac};
    end

    // S3 register
    always_ff @(posedge clk) begin
        if (rst && vld_pipe[2]) s3_q <= s3_d;
    end

    // S4: output register, holds its value through bubbles
    always_ff @(posedge clk) begin
        if (!rst)             res <= 32'h0;
        else if (vld_pipe[3]) res <= s3_q;
    end
endmodule

// File: tb/tb_double_multiplier_core.sv
// Scoreboard bench for double_multiplier_core: the driver pushes hand-computed
// products with their due cycle; a monitor pops and checks on every done.
module tb_double_multiplier_core;
    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [31:0] op1, op2;
    logic [31:0] res;
    logic        done;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    double_multiplier_core dut (
        .clk   (clk),
        .rst   (rst),
        .ready (ready),
        .op1   (op1),
        .op2   (op2),
        .res   (res),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one operand pair; it is captured at the next rising edge and is due 4 edges later
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        exp_t x;
        @(negedge clk);
        ready = 1'b1;
        op1   = a;
        op2   = b;
        x.val = e;
        x.cyc = cyc + 5;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ready = 1'b0;
            op1   = $urandom;
            op2   = $urandom;
        end
    endtask

    // Monitor: reset state, result/latency on done, hold value in bubbles
    initial begin
        logic        rst_edge;
        logic [31:0] last_res;
        exp_t        x;
        last_res = 32'h0;
        forever begin
            @(posedge clk);
            rst_edge = rst;
            #1;
            if (!rst_edge) begin
                checks++;
                if (done !== 1'b0 || res !== 32'h0) begin
                    fails++;
                    $display("FAIL reset_state: got done=%b res=%h, need done=0 res=00000000", done, res);
                end
                last_res = 32'h0;
            end else if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: res=%h at cycle %0d with nothing outstanding", res, cyc);
                end else begin
                    x = exp_q.pop_front();
                    checks++;
                    if (res !== x.val) begin
                        fails++;
                        $display("FAIL result: got %h, need %h (cycle %0d)", res, x.val, cyc);
                    end
                    checks++;
                    if (cyc != x.cyc) begin
                        fails++;
                        $display("FAIL latency: done at cycle %0d, need cycle %0d", cyc, x.cyc);
                    end
                    last_res = x.val;
                end
            end else begin
                checks++;
                if (done !== 1'b0 || res !== last_res) begin
                    fails++;
                    $display("FAIL bubble_hold: got done=%b res=%h, need done=0 res=%h", done, res, last_res);
                end
            end
        end
    end

    initial begin
        rst   = 1'b0;
        ready = 1'b1;
        op1   = 32'h3F800000;
        op2   = 32'h3F800000;
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        ready = 1'b0;
        idle(2);

        // specials back to back
        issue(32'hFF800000, 32'h40000000, 32'hFF800000);
        issue(32'h3FA00000, 32'h00000000, 32'h00000000);
        // NaN from inf x zero, and from a NaN operand
        issue(32'hFF800000, 32'h00000000, 32'hFFFFFFFF);
        issue(32'h7F800000, 32'h00000000, 32'h7FFFFFFF);
        issue(32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF);
        idle(2);
        // exact products
        issue(32'h41820000, 32'h41100000, 32'h43124000);
        issue(32'h41B00000, 32'hC0A00000, 32'hC2DC0000);
        issue(32'h3F800000, 32'hBF800000, 32'hBF800000);
        idle(1);
        // rounding
        issue(32'h4059999A, 32'h4059999A, 32'h4138F5C3);
        issue(32'h42A7A8F6, 32'h3E0F5C29, 32'h413BC77A);
        issue(32'h42F778F2, 32'h3AA137F4, 32'h3E1BD927);
        issue(32'h4291CCCD, 32'h41100000, 32'h44240667);
        idle(3);
        // overflow, underflow, denormal flush, negative zero
        issue(32'h7F000000, 32'h40400000, 32'h7F800000);
        issue(32'h00800000, 32'h00800000, 32'h00000000);
        issue(32'h00400000, 32'h40000000, 32'h00000000);
        issue(32'h80000000, 32'h40A00000, 32'h80000000);
        idle(8);

        // reset with two pairs in flight: they must never produce done
        issue(32'h41820000, 32'h41100000, 32'h43124000);
        issue(32'h41B00000, 32'hC0A00000, 32'hC2DC0000);
        @(negedge clk);
        rst   = 1'b0;
        ready = 1'b1;
        op1   = 32'h40000000;
        op2   = 32'h40000000;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        ready = 1'b0;
        idle(2);
        // first capture after reset keeps normal latency
        issue(32'h4059999A, 32'h4059999A, 32'h4138F5C3);
        idle(1);

        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, need 0", exp_q.size());
        end
        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
